// File: rtl/main_mem.sv
// main_mem: fixed-latency, fully pipelined main memory model.
//
// Each accepted request enters a MEM_LATENCY-deep valid/tag/data pipeline.
// A READ captures the block at the acceptance edge. A WRITE merges a
// BYTE/HALF/WORD into the block at the acceptance edge, with the offset
// aligned down to the access size. Storage is never cleared by reset.
//
// Optional feature: define MAIN_MEM_WRITE_ACK_EN to also answer each WRITE
// with the post-write block contents. When it is undefined, a WRITE leaves an
// empty (valid=0) slot in the response pipeline.
//
// Ports:
//   clk                 rising-edge clock
//   rst_aL              asynchronous active-low reset (pipeline only)
//   mem_req_valid       request present this cycle (always accepted)
//   mem_req_cache_type  requester tag, echoed on the response
//   mem_req_type        READ / WRITE
//   mem_req_block_addr  block index (>= NUM_BLOCKS reads zero, writes ignored)
//   mem_req_block_data  store value, held in the low bytes
//   mem_req_width       store width BYTE / HALF / WORD
//   mem_req_addr        store byte address; the low 4 bits give the offset
//   mem_resp_valid      response present this cycle
//   mem_resp_cache_type tag of the answered request (0 when not valid)
//   mem_resp_block_data response block data (0 when not valid)

package main_mem_pkg;
  typedef enum logic {ICACHE = 1'b0, DCACHE = 1'b1} cache_type_t;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} req_type_t;
  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} req_width_t;
  typedef logic [31:0]  addr_t;
  typedef logic [27:0]  main_mem_block_addr_t;
  typedef logic [127:0] block_data_t;
  localparam int BLOCK_BYTES = 16;
endpackage

module main_mem
  import main_mem_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int NUM_BLOCKS  = 1024
) (
  input  logic                 clk,
  input  logic                 rst_aL,
  input  logic                 mem_req_valid,
  input  cache_type_t          mem_req_cache_type,
  input  req_type_t            mem_req_type,
  input  main_mem_block_addr_t mem_req_block_addr,
  input  block_data_t          mem_req_block_data,
  input  req_width_t           mem_req_width,
  input  addr_t                mem_req_addr,
  output logic                 mem_resp_valid,
  output cache_type_t          mem_resp_cache_type,
  output block_data_t          mem_resp_block_data
);

  localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam main_mem_block_addr_t LIMIT = main_mem_block_addr_t'(NUM_BLOCKS);

  block_data_t mem_r [NUM_BLOCKS];

  logic        valid_r [MEM_LATENCY];
  cache_type_t tag_r   [MEM_LATENCY];
  block_data_t data_r  [MEM_LATENCY];

  logic             in_range_s;
  logic [IDX_W-1:0] idx_s;
  block_data_t      rd_block_s;
  block_data_t      merged_s;
  logic [3:0]       base_s;
  logic [2:0]       nbytes_s;
  logic [3:0]       lane_s;
  logic             wr_en_s;
  logic             s0_valid_s;
  cache_type_t      s0_tag_s;
  block_data_t      s0_data_s;
  logic             unused_addr_s;

  // Only the in-block byte offset of the store address matters.
  assign unused_addr_s = ^mem_req_addr[31:4];

  assign in_range_s = (mem_req_block_addr < LIMIT);
  assign idx_s      = mem_req_block_addr[IDX_W-1:0];
  assign rd_block_s = in_range_s ? mem_r[idx_s] : '0;
  assign wr_en_s    = rst_aL && mem_req_valid && (mem_req_type == WRITE) && in_range_s;

  // Store merge: align the offset down to the access size, replace only those bytes.
  always_comb begin
    merged_s = rd_block_s;
    base_s   = mem_req_addr[3:0];
    nbytes_s = 3'd0;
    lane_s   = 4'd0;
    case (mem_req_width)
      BYTE: begin
        base_s   = mem_req_addr[3:0];
        nbytes_s = 3'd1;
      end
      HALF: begin
        base_s   = {mem_req_addr[3:1], 1'b0};
        nbytes_s = 3'd2;
      end
      WORD: begin
        base_s   = {mem_req_addr[3:2], 2'b00};
        nbytes_s = 3'd4;
      end
      default: begin
        base_s   = mem_req_addr[3:0];
        nbytes_s = 3'd0;
      end
    endcase
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      // lane_s is the source byte within the store value for block byte i.
      lane_s = 4'(i) - base_s;
      if ((4'(i) >= base_s) && (lane_s < {1'b0, nbytes_s})) begin
        merged_s[8*i +: 8] = mem_req_block_data[{lane_s, 3'b000} +: 8];
      end else begin
        merged_s[8*i +: 8] = rd_block_s[8*i +: 8];
      end
    end
  end

  // Pipeline entry: what the accepted request will return (zeroed when no response).
  always_comb begin
    s0_valid_s = 1'b0;
    s0_tag_s   = ICACHE;
    s0_data_s  = '0;
    if (mem_req_valid && (mem_req_type == READ)) begin
      s0_valid_s = 1'b1;
      s0_tag_s   = mem_req_cache_type;
      s0_data_s  = rd_block_s;
    end else if (mem_req_valid) begin
`ifdef MAIN_MEM_WRITE_ACK_EN
      s0_valid_s = 1'b1;
      s0_tag_s   = mem_req_cache_type;
      s0_data_s  = in_range_s ? merged_s : '0;
`else
      s0_valid_s = 1'b0;
      s0_tag_s   = ICACHE;
      s0_data_s  = '0;
`endif
    end else begin
      s0_valid_s = 1'b0;
      s0_tag_s   = ICACHE;
      s0_data_s  = '0;
    end
  end

  // Backing storage: no reset, so committed writes survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[idx_s] <= merged_s;
    end
  end

  // Response pipeline: async reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      for (int k = 0; k < MEM_LATENCY; k++) begin
        valid_r[k] <= 1'b0;
        tag_r[k]   <= ICACHE;
        data_r[k]  <= '0;
      end
    end else begin
      valid_r[0] <= s0_valid_s;
      tag_r[0]   <= s0_tag_s;
      data_r[0]  <= s0_data_s;
      for (int k = 1; k < MEM_LATENCY; k++) begin
        valid_r[k] <= valid_r[k-1];
        tag_r[k]   <= tag_r[k-1];
        data_r[k]  <= data_r[k-1];
      end
    end
  end

  // Last stage drives the outputs directly; tag/data are already 0 in empty slots.
  assign mem_resp_valid      = valid_r[MEM_LATENCY-1];
  assign mem_resp_cache_type = tag_r[MEM_LATENCY-1];
  assign mem_resp_block_data = data_r[MEM_LATENCY-1];

endmodule
